bitrev_reorder: RTL

//  Output-side reorder buffer for the R2^2 SDF FFT pipeline. Takes the bit-reversed

---
 rtl/bitrev_reorder.sv | 119 +++++++++++
 1 files changed

// File: rtl/bitrev_reorder.sv
// bitrev_reorder: output-side reorder buffer for an R2^2 SDF FFT pipeline.
// Accepts a bit-reversed complex sample stream and emits each N-point frame in
// natural order as one contiguous N-cycle burst. Two RAM banks ping-pong: one
// fills while the other drains.
//
// Ports:
//   clock        master clock, rising edge
//   reset        asynchronous, active-high reset
//   di_en        input sample valid (at most one per cycle, gaps allowed)
//   di_re/di_im  input sample, bit-reversed frame order
//   do_en        output sample valid
//   do_re/do_im  output sample, natural order; hold last value when do_en=0
module bitrev_reorder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LOG_N = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int unsigned N = 1 << LOG_N;

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
    return r;
  endfunction

  // Write side
  logic [LOG_N-1:0] wr_cnt;
  logic             wr_bank;
  logic             frame_done;

  // Last sample of a frame is being accepted this cycle.
  assign frame_done = di_en && (wr_cnt == '1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (di_en) begin
      wr_cnt <= wr_cnt + LOG_N'(1);  // wraps to 0 after N-1
      if (frame_done) wr_bank <= ~wr_bank;
    end
  end

  // Read FSM
  state_e           state_q, state_d;
  logic [LOG_N-1:0] rd_cnt;
  logic             rd_bank;
  logic             rd_active;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (frame_done) state_d = StRead;
      // A frame completing on the last read cycle continues the burst with no bubble.
      StRead: if (rd_cnt == '1 && !frame_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_active = (state_q == StRead);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      if (rd_active) rd_cnt <= rd_cnt + LOG_N'(1);  // wraps to 0, ready for a restart
      // Only ever fires at burst start: frames take >= N cycles to arrive.
      if (frame_done) rd_bank <= wr_bank;
    end
  end

  // Storage: {bank, addr} indexed, contents not reset
  logic [2*WIDTH-1:0] mem [2*N];
  logic [2*WIDTH-1:0] rd_data;

  always_ff @(posedge clock) begin
    if (di_en) mem[{wr_bank, bitrev(wr_cnt)}] <= {di_re, di_im};
    if (rd_active) rd_data <= mem[{rd_bank, rd_cnt}];
  end

  // Output pipeline: RAM read stage then output register
  logic rd_vld;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_vld <= 1'b0;
      do_en  <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
    end else begin
      rd_vld <= rd_active;
      do_en  <= rd_vld;
      if (rd_vld) begin
        do_re <= rd_data[2*WIDTH-1:WIDTH];
        do_im <= rd_data[WIDTH-1:0];
      end
    end
  end

endmodule
